fc_classifier: RTL and testbench

//  Fully-connected output stage directly downstream of max_pooling. Captures one flattened pooled

---
 rtl/fc_classifier_pkg.sv | 66 ++++++
 rtl/fc_classifier_if.sv | 32 +++
 rtl/fc_weight_rom.sv | 29 ++
 rtl/fc_classifier.sv | 185 ++++++++++++++++++
 tb/tb_fc_classifier.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fc_classifier_pkg.sv
// Shared constants, types and helpers for the fully-connected classifier stage.
// Weight/bias contents are selected per instance by a fc_prof_e profile.
package fc_classifier_pkg;

    localparam int unsigned FC_IN_VEC = 48;
    localparam int unsigned IN_BW     = 32;
    localparam int unsigned W_BW      = 8;
    localparam int unsigned B_BW      = 16;
    localparam int unsigned NUM_CLASS = 26;
    localparam int unsigned ACC_BW    = 46;
    localparam int unsigned OUT_SHIFT = 0;
    localparam int unsigned OUT_BW    = 32;

    localparam int unsigned SUM_BW    = ACC_BW + 1;
    localparam int unsigned CNT_BW    = $clog2(FC_IN_VEC + 1);
    localparam int unsigned CLS_BW    = $clog2(NUM_CLASS);
    localparam int unsigned ROM_DEPTH = NUM_CLASS * FC_IN_VEC;
    localparam int unsigned ADDR_BW   = $clog2(ROM_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StBias,
        StDone
    } fc_state_e;

    typedef enum logic [2:0] {
        ProfUnit,
        ProfMax,
        ProfRamp,
        ProfHot,
        ProfTie
    } fc_prof_e;

    function automatic logic signed [W_BW-1:0] fc_weight(input fc_prof_e prof,
                                                        input int unsigned row);
        logic signed [W_BW-1:0] w;
        w = W_BW'(1);
        case (prof)
            ProfMax: w = W_BW'(127);
            ProfHot: if (row == 7) w = W_BW'(2);
            ProfTie: if (row == 3 || row == 5) w = W_BW'(2);
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic signed [B_BW-1:0] fc_bias(input fc_prof_e prof,
                                                      input int unsigned row);
        return (prof == ProfRamp) ? B_BW'(row) : '0;
    endfunction

    // Clamp to the signed OUT_BW range; in range iff all bits above the sign agree with it.
    function automatic logic signed [OUT_BW-1:0] fc_saturate(input logic signed [SUM_BW-1:0] v);
        logic [SUM_BW-OUT_BW:0] top;
        top = v[SUM_BW-1:OUT_BW-1];
        if ((&top) || !(|top)) begin
            return v[OUT_BW-1:0];
        end else if (v[SUM_BW-1]) begin
            return {1'b1, {(OUT_BW-1){1'b0}}};
        end else begin
            return {1'b0, {(OUT_BW-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/fc_classifier_if.sv
// Input-vector / score-vector bundle between max_pooling, fc_classifier and its consumer.
import fc_classifier_pkg::*;

interface fc_classifier_if;
    logic                        i_in_valid;
    logic [FC_IN_VEC*IN_BW-1:0]  i_in_vec;
    logic                        o_in_ready;
    logic                        o_ot_valid;
    logic [NUM_CLASS*OUT_BW-1:0] o_ot_score;
    logic [CLS_BW-1:0]           o_class_idx;
    logic                        o_drop;

    modport master (
        output i_in_valid,
        output i_in_vec,
        input  o_in_ready,
        input  o_ot_valid,
        input  o_ot_score,
        input  o_class_idx,
        input  o_drop
    );

    modport slave (
        input  i_in_valid,
        input  i_in_vec,
        output o_in_ready,
        output o_ot_valid,
        output o_ot_score,
        output o_class_idx,
        output o_drop
    );
endinterface

// File: rtl/fc_weight_rom.sv
// Synchronous-read weight ROM, address = class*FC_IN_VEC + element, one cycle read latency.
import fc_classifier_pkg::*;

module fc_weight_rom #(
    parameter fc_prof_e Prof = ProfUnit
) (
    input  logic                     clk_i,
    input  logic [ADDR_BW-1:0]       addr_i,
    output logic signed [W_BW-1:0]   rdata_o
);

    logic signed [W_BW-1:0] rom [ROM_DEPTH];
    logic signed [W_BW-1:0] rdata_d, rdata_q;

    for (genvar a = 0; a < ROM_DEPTH; a++) begin : g_rom
        assign rom[a] = fc_weight(Prof, a / FC_IN_VEC);
    end

    always_comb begin
        rdata_d = rom[addr_i];
    end

    always_ff @(posedge clk_i) begin
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fc_classifier.sv
// Fully-connected output stage: sequential MAC per class, bias, shift, saturate, score-vector pulse.
// Optional argmax output enabled by defining FC_ARGMAX_EN.
import fc_classifier_pkg::*;

module fc_classifier #(
    parameter fc_prof_e Prof = ProfUnit
) (
    input  logic            clk,
    input  logic            reset_n,
    fc_classifier_if.slave  bus
);

    fc_state_e                 state_q, state_d;
    logic [CNT_BW-1:0]         cnt_q, cnt_d;
    logic [CLS_BW-1:0]         cls_q, cls_d;
    logic signed [ACC_BW-1:0]  acc_q, acc_d;
    logic signed [IN_BW-1:0]   vec_q [FC_IN_VEC];
    logic signed [IN_BW-1:0]   vec_d [FC_IN_VEC];
    logic signed [OUT_BW-1:0]  score_q [NUM_CLASS];
    logic signed [OUT_BW-1:0]  score_d [NUM_CLASS];
    logic                      ot_valid_q, ot_valid_d;
    logic                      drop_q, drop_d;

    logic                      in_ready;
    logic [ADDR_BW-1:0]        rom_addr;
    logic signed [W_BW-1:0]    rom_rdata;
    logic [CNT_BW-1:0]         x_idx;
    logic signed [ACC_BW-1:0]  x_ext, w_ext, prod;
    logic signed [SUM_BW-1:0]  biased, shifted;
    logic signed [OUT_BW-1:0]  score_val;
    logic signed [B_BW-1:0]    bias_tab [NUM_CLASS];

    for (genvar c = 0; c < NUM_CLASS; c++) begin : g_bias
        assign bias_tab[c] = fc_bias(Prof, c);
    end

    fc_weight_rom #(
        .Prof (Prof)
    ) u_rom (
        .clk_i   (clk),
        .addr_i  (rom_addr),
        .rdata_o (rom_rdata)
    );

    assign in_ready = (state_q == StIdle);

    // Address issued in MAC cycles 0..FC_IN_VEC-1; its data is consumed one cycle later.
    always_comb begin
        rom_addr = '0;
        if (state_q == StMac && cnt_q < CNT_BW'(FC_IN_VEC)) begin
            rom_addr = ADDR_BW'(cls_q) * ADDR_BW'(FC_IN_VEC) + ADDR_BW'(cnt_q);
        end
    end

    always_comb begin
        x_idx     = (cnt_q == '0) ? '0 : cnt_q - CNT_BW'(1);
        x_ext     = ACC_BW'(vec_q[x_idx]);
        w_ext     = ACC_BW'(rom_rdata);
        prod      = x_ext * w_ext;
        biased    = SUM_BW'(acc_q) + SUM_BW'(bias_tab[cls_q]);
        shifted   = biased >>> OUT_SHIFT;
        score_val = fc_saturate(shifted);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cls_d      = cls_q;
        acc_d      = acc_q;
        vec_d      = vec_q;
        score_d    = score_q;
        ot_valid_d = 1'b0;
        drop_d     = drop_q | (bus.i_in_valid & ~in_ready);

        unique case (state_q)
            StIdle: begin
                if (bus.i_in_valid) begin
                    state_d = StMac;
                    cnt_d   = '0;
                    cls_d   = '0;
                    acc_d   = '0;
                    for (int i = 0; i < FC_IN_VEC; i++) begin
                        vec_d[i] = bus.i_in_vec[i*IN_BW +: IN_BW];
                    end
                end
            end
            StMac: begin
                if (cnt_q != '0) begin
                    acc_d = acc_q + prod;
                end
                if (cnt_q == CNT_BW'(FC_IN_VEC)) begin
                    state_d = StBias;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_BW'(1);
                end
            end
            StBias: begin
                score_d[cls_q] = score_val;
                acc_d          = '0;
                if (cls_q == CLS_BW'(NUM_CLASS - 1)) begin
                    state_d = StDone;
                end else begin
                    state_d = StMac;
                    cls_d   = cls_q + CLS_BW'(1);
                end
            end
            StDone: begin
                ot_valid_d = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cls_q      <= '0;
            acc_q      <= '0;
            vec_q      <= '{default: '0};
            score_q    <= '{default: '0};
            ot_valid_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cls_q      <= cls_d;
            acc_q      <= acc_d;
            vec_q      <= vec_d;
            score_q    <= score_d;
            ot_valid_q <= ot_valid_d;
            drop_q     <= drop_d;
        end
    end

`ifdef FC_ARGMAX_EN
    logic signed [OUT_BW-1:0] max_q, max_d;
    logic [CLS_BW-1:0]        max_idx_q, max_idx_d;
    logic [CLS_BW-1:0]        idx_q, idx_d;

    // Strict compare keeps the lowest index on ties; class 0 always seeds the running max.
    always_comb begin
        max_d     = max_q;
        max_idx_d = max_idx_q;
        idx_d     = idx_q;
        if (state_q == StBias && (cls_q == '0 || score_val > max_q)) begin
            max_d     = score_val;
            max_idx_d = cls_q;
        end
        if (state_q == StDone) begin
            idx_d = max_idx_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_q     <= '0;
            max_idx_q <= '0;
            idx_q     <= '0;
        end else begin
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            idx_q     <= idx_d;
        end
    end

    assign bus.o_class_idx = idx_q;
`else
    assign bus.o_class_idx = '0;
`endif

    always_comb begin
        bus.o_ot_score = '0;
        for (int c = 0; c < NUM_CLASS; c++) begin
            bus.o_ot_score[c*OUT_BW +: OUT_BW] = score_q[c];
        end
    end

    assign bus.o_in_ready = in_ready;
    assign bus.o_ot_valid = ot_valid_q;
    assign bus.o_drop     = drop_q;

endmodule

// File: tb/tb_fc_classifier.sv
// Directed bench: five classifier instances (one per weight profile) driven in lockstep.
import fc_classifier_pkg::*;

module tb_fc_classifier;

    localparam int NP = 5;
    localparam int LAT = 1 + NUM_CLASS * (FC_IN_VEC + 2);

    logic clk;
    logic reset_n;
    logic in_valid;
    logic [FC_IN_VEC*IN_BW-1:0] in_vec;

    logic ready [NP];
    logic otv [NP];
    logic drop [NP];
    logic [NUM_CLASS*OUT_BW-1:0] score [NP];
    logic [CLS_BW-1:0] cidx [NP];

    for (genvar g = 0; g < NP; g++) begin : g_dut
        fc_classifier_if u_if ();
        assign u_if.i_in_valid = in_valid;
        assign u_if.i_in_vec   = in_vec;
        assign ready[g] = u_if.o_in_ready;
        assign otv[g]   = u_if.o_ot_valid;
        assign drop[g]  = u_if.o_drop;
        assign score[g] = u_if.o_ot_score;
        assign cidx[g]  = u_if.o_class_idx;

        fc_classifier #(
            .Prof (fc_prof_e'(g))
        ) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (u_if)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          txn;
        int          prof;
        int          cls;
        logic [31:0] exp;
    } row_t;

    typedef struct {
        int txn;
        int prof;
        int idx;
    } amax_t;

    row_t        rows[$];
    amax_t       amax[$];
    logic [31:0] txn_x [4];
    int          n_checks;
    int          n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic start_txn(input logic [31:0] x);
        for (int i = 0; i < FC_IN_VEC; i++) in_vec[i*IN_BW +: IN_BW] = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int n0, output int lat, output int rdy_bad);
        lat = n0;
        rdy_bad = 0;
        while (lat < 2000) begin
            @(posedge clk);
            lat++;
            #1;
            if (otv[0]) break;
            if (ready[0]) rdy_bad++;
        end
    endtask

    function automatic logic [31:0] slot(input int p, input int c);
        return score[p][c*OUT_BW +: OUT_BW];
    endfunction

    task automatic check_reset_state(input string tag);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("%s ready p%0d", tag, p), 32'(ready[p]), 32'd1);
            check($sformatf("%s valid p%0d", tag, p), 32'(otv[p]), 32'd0);
            check($sformatf("%s score p%0d", tag, p), 32'(|score[p]), 32'd0);
            check($sformatf("%s idx p%0d", tag, p), 32'(cidx[p]), 32'd0);
            check($sformatf("%s drop p%0d", tag, p), 32'(drop[p]), 32'd0);
        end
    endtask

    initial begin
        int lat;
        int bad;
        n_checks = 0;
        n_pass   = 0;
        txn_x[0] = 32'h0000_0001;
        txn_x[1] = 32'h7FFF_FFFF;
        txn_x[2] = 32'h8000_0000;
        txn_x[3] = 32'hFFFF_FFFF;

        // profiles: 0 unit, 1 w=127, 2 bias=c, 3 row7 w=2, 4 rows3/5 w=2
        rows.push_back('{0, 0, 0, 32'd48});
        rows.push_back('{0, 0, 25, 32'd48});
        rows.push_back('{0, 1, 0, 32'd6096});
        rows.push_back('{0, 1, 13, 32'd6096});
        rows.push_back('{0, 2, 0, 32'd48});
        rows.push_back('{0, 2, 25, 32'd73});
        rows.push_back('{0, 3, 7, 32'd96});
        rows.push_back('{0, 3, 6, 32'd48});
        rows.push_back('{0, 4, 3, 32'd96});
        rows.push_back('{0, 4, 5, 32'd96});
        rows.push_back('{0, 4, 4, 32'd48});
        rows.push_back('{1, 0, 0, 32'h7FFF_FFFF});
        rows.push_back('{1, 1, 25, 32'h7FFF_FFFF});
        rows.push_back('{1, 2, 25, 32'h7FFF_FFFF});
        rows.push_back('{1, 3, 7, 32'h7FFF_FFFF});
        rows.push_back('{2, 0, 0, 32'h8000_0000});
        rows.push_back('{2, 1, 25, 32'h8000_0000});
        rows.push_back('{2, 2, 25, 32'h8000_0000});
        rows.push_back('{3, 2, 0, 32'hFFFF_FFD0});
        rows.push_back('{3, 2, 10, 32'hFFFF_FFDA});
        rows.push_back('{3, 2, 25, 32'hFFFF_FFE9});
        rows.push_back('{3, 0, 12, 32'hFFFF_FFD0});
        rows.push_back('{3, 1, 0, 32'hFFFF_E830});
        rows.push_back('{3, 3, 7, 32'hFFFF_FFA0});
        rows.push_back('{3, 4, 3, 32'hFFFF_FFA0});

        amax.push_back('{0, 0, 0});
        amax.push_back('{0, 2, 25});
        amax.push_back('{0, 3, 7});
        amax.push_back('{0, 4, 3});
        amax.push_back('{1, 0, 0});
        amax.push_back('{3, 2, 25});
        amax.push_back('{3, 3, 0});
        amax.push_back('{3, 4, 0});

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_vec   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 4; t++) begin
            start_txn(txn_x[t]);
            wait_valid(0, lat, bad);
            check($sformatf("latency t%0d", t), 32'(lat), 32'(LAT));
            check($sformatf("ready low t%0d", t), 32'(bad), 32'd0);
            for (int p = 1; p < NP; p++) check($sformatf("valid t%0d p%0d", t, p), 32'(otv[p]), 32'd1);
            foreach (rows[r]) begin
                if (rows[r].txn == t) begin
                    check($sformatf("score t%0d p%0d c%0d", t, rows[r].prof, rows[r].cls),
                          slot(rows[r].prof, rows[r].cls), rows[r].exp);
                end
            end
`ifdef FC_ARGMAX_EN
            foreach (amax[a]) begin
                if (amax[a].txn == t) begin
                    check($sformatf("argmax t%0d p%0d", t, amax[a].prof),
                          32'(cidx[amax[a].prof]), 32'(amax[a].idx));
                end
            end
`else
            check($sformatf("idx tied t%0d", t), 32'(cidx[2]), 32'd0);
`endif
            @(posedge clk);
            #1;
            check($sformatf("pulse width t%0d", t), 32'(otv[0]), 32'd0);
        end
        check("drop clear", 32'(drop[0]), 32'd0);

        // second vector mid-compute is dropped, first result intact
        start_txn(32'd1);
        repeat (9) @(posedge clk);
        #1;
        for (int i = 0; i < FC_IN_VEC; i++) in_vec[i*IN_BW +: IN_BW] = 32'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("drop set", 32'(drop[0]), 32'd1);
        check("busy ready", 32'(ready[0]), 32'd0);
        wait_valid(10, lat, bad);
        check("drop latency", 32'(lat), 32'(LAT));
        check("drop ready low", 32'(bad), 32'd0);
        check("drop score c0", slot(0, 0), 32'd48);
        check("drop score c25", slot(0, 25), 32'd48);
        check("drop sticky", 32'(drop[0]), 32'd1);
        @(posedge clk);
        #1;

        // asynchronous reset mid-compute
        start_txn(32'd1);
        repeat (499) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_state("abort");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        start_txn(32'd1);
        wait_valid(0, lat, bad);
        check("post-reset latency", 32'(lat), 32'(LAT));
        check("post-reset c0", slot(0, 0), 32'd48);
        check("post-reset c25", slot(0, 25), 32'd48);
        check("post-reset ramp c25", slot(2, 25), 32'd73);
        check("post-reset drop", 32'(drop[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
